// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the ALU control decoder and
// the execute unit, plus the execute-unit FSM states.
package alu_pkg;

   localparam logic [3:0] ALU_AND     = 4'b0000;
   localparam logic [3:0] ALU_OR      = 4'b0001;
   localparam logic [3:0] ALU_ADD     = 4'b0010;
   localparam logic [3:0] ALU_SLL     = 4'b0011;
   localparam logic [3:0] ALU_SRL     = 4'b0100;
   localparam logic [3:0] ALU_SRA     = 4'b0101;
   localparam logic [3:0] ALU_SUB     = 4'b0110;
   localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

   localparam logic [1:0] SK_SLL = 2'd0;
   localparam logic [1:0] SK_SRL = 2'd1;
   localparam logic [1:0] SK_SRA = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic is_shift_op(input logic [3:0] c);
      return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
   endfunction

   function automatic logic is_legal(input logic [3:0] c);
      return is_shift_op(c) || (c == ALU_ADD) || (c == ALU_SUB) ||
             (c == ALU_AND) || (c == ALU_OR);
   endfunction

   function automatic logic [1:0] shift_kind(input logic [3:0] c);
      case (c)
         ALU_SRL: return SK_SRL;
         ALU_SRA: return SK_SRA;
         default: return SK_SLL;
      endcase
   endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter: working register, down counter and fill.
// dout/busy look one step ahead so the owner can capture the final value on the
// same edge the counter reaches zero.
module alu_shift_unit
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      kind,
   input  logic [XLEN-1:0] src,
   input  logic [4:0]      shamt,
   output logic            busy,
   output logic [XLEN-1:0] dout
);

   logic [XLEN-1:0] work;
   logic [XLEN-1:0] step;
   logic [4:0]      cnt;
   logic [1:0]      kind_q;

   always_comb begin
      step = work;
      case (kind_q)
         SK_SLL:  step = {work[XLEN-2:0], 1'b0};
         SK_SRL:  step = {1'b0, work[XLEN-1:1]};
         SK_SRA:  step = {work[XLEN-1], work[XLEN-1:1]};
         default: step = work;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work   <= '0;
         cnt    <= '0;
         kind_q <= SK_SLL;
      end else if (start) begin
         work   <= src;
         cnt    <= shamt;
         kind_q <= kind;
      end else if (cnt != 5'd0) begin
         work <= step;
         cnt  <= cnt - 5'd1;
      end
   end

   // busy drops during the last step; dout then already holds the final value
   assign busy = (cnt > 5'd1);
   assign dout = (cnt != 5'd0) ? step : work;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle add/sub/and/or, iterative shifts, and a
// valid/ready handshake on both sides with a held result.
module alu_exec
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   state_t          state, state_nx;
   logic            accept;
   logic            sh_start;
   logic            sh_busy;
   logic [XLEN-1:0] sh_dout;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] res_q;
   logic            zero_q;
   logic            ill_q;

   assign accept   = in_valid && in_ready;
   assign sh_start = accept && is_shift_op(alu_ctrl) && (op_b[4:0] != 5'd0);

   // shifts by zero pass op_a straight through without entering SHIFT
   always_comb begin
      alu_res = '0;
      case (alu_ctrl)
         ALU_ADD:                   alu_res = op_a + op_b;
         ALU_SUB:                   alu_res = op_a - op_b;
         ALU_AND:                   alu_res = op_a & op_b;
         ALU_OR:                    alu_res = op_a | op_b;
         ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
         default:                   alu_res = '0;
      endcase
   end

   alu_shift_unit #(.XLEN(XLEN)) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .start (sh_start),
      .kind  (shift_kind(alu_ctrl)),
      .src   (op_a),
      .shamt (op_b[4:0]),
      .busy  (sh_busy),
      .dout  (sh_dout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (accept) state_nx = sh_start ? ST_SHIFT : ST_DONE;
         ST_SHIFT: if (!sh_busy) state_nx = ST_DONE;
         ST_DONE:  if (out_ready) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q  <= '0;
         zero_q <= 1'b0;
         ill_q  <= 1'b0;
      end else if (accept) begin
         res_q  <= alu_res;
         zero_q <= (alu_res == '0);
         ill_q  <= !is_legal(alu_ctrl);
      end else if (state == ST_SHIFT && !sh_busy) begin
         res_q  <= sh_dout;
         zero_q <= (sh_dout == '0);
      end
   end

   assign result  = res_q;
   assign zero    = zero_q;
   assign illegal = ill_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, handshake corner
// sequences and random ops against an arithmetic reference model.
module tb_alu_exec;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_ctrl;
   logic [XLEN-1:0] op_a, op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   int n_chk  = 0;
   int n_fail = 0;

   alu_exec #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic       z;
      logic       ill;
      int         lat;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Reference: plain arithmetic on the operation semantics; latency is k+1 for shifts
   task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic ill, output int lat);
      int sh;
      sh  = int'(b[4:0]);
      ill = 1'b0;
      lat = 1;
      case (c)
         4'b0010: r = a + b;
         4'b0110: r = a - b;
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0011: begin r = a << sh; lat = sh + 1; end
         4'b0100: begin r = a >> sh; lat = sh + 1; end
         4'b0101: begin r = $unsigned($signed(a) >>> sh); lat = sh + 1; end
         default: begin r = 32'd0; ill = 1'b1; end
      endcase
   endtask

   // Called #1 after a posedge with the unit idle and out_ready high.
   task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ez,
                         input logic ei, input int elat);
      int lat;
      check({nm, " in_ready before"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({nm, " out_valid"}, {31'd0, out_valid}, 32'd1);
      check({nm, " latency"}, lat, elat);
      check({nm, " result"}, result, er);
      check({nm, " zero"}, {31'd0, zero}, {31'd0, ez});
      check({nm, " illegal"}, {31'd0, illegal}, {31'd0, ei});
      @(posedge clk); #1;
      check({nm, " handoff"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   vec_t vecs[$];

   initial begin
      logic [31:0] mr;
      logic        mi;
      int          ml;
      logic [3:0]  c;
      logic [31:0] a, b;

      vecs.push_back('{"add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1});
      vecs.push_back('{"sub_eq",   4'b0110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1});
      vecs.push_back('{"and_zero", 4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 1'b1, 1'b0, 1});
      vecs.push_back('{"sub_wrap", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1});
      vecs.push_back('{"sra_4",    4'b0101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 5});
      vecs.push_back('{"srl_4",    4'b0100, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 5});
      vecs.push_back('{"sll_0",    4'b0011, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0, 1});
      vecs.push_back('{"ill_f",    4'b1111, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b1, 1});
      vecs.push_back('{"ill_7",    4'b0111, 32'hFFFF, 32'h1, 32'h0, 1'b1, 1'b1, 1});
      vecs.push_back('{"or_clr",   4'b0001, 32'hA000_0000, 32'h0000_0005, 32'hA000_0005, 1'b0, 1'b0, 1});
      vecs.push_back('{"sra_31",   4'b0101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32});
      vecs.push_back('{"sll_hi",   4'b0011, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, 1'b0, 1'b0, 2});

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_ctrl = 4'd0; op_a = '0; op_b = '0;
      #3;
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset result", result, 32'd0);
      check("reset zero/illegal", {30'd0, zero, illegal}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].z, vecs[i].ill, vecs[i].lat);

      // Backpressure: result held 6 cycles, pending offer waits for handoff
      out_ready = 1'b0;
      in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd3; op_b = 32'd4;
      @(posedge clk); #1;
      alu_ctrl = 4'b0001; op_a = 32'h0F00; op_b = 32'h00F0;
      check("bp first valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("bp hold", {out_valid, in_ready, zero, illegal, 28'd0} | (result & 32'h0FFF_FFFF),
               32'h8000_0007);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp handoff", {30'd0, out_valid, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp second valid", {31'd0, out_valid}, 32'd1);
      check("bp second result", result, 32'h0FF0);
      @(posedge clk); #1;

      // Reset during the 3rd SHIFT cycle of SLL by 20
      in_valid = 1'b1; alu_ctrl = 4'b0011; op_a = 32'h1; op_b = 32'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("pre-abort busy", {30'd0, out_valid, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort out_valid", {31'd0, out_valid}, 32'd0);
      check("abort result", result, 32'd0);
      check("abort in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("post_abort_add", 4'b0010, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1);

      // Random ops against the reference model
      for (int i = 0; i < 60; i++) begin
         c = 4'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
         if ($urandom_range(0, 5) == 0) b = a;
         model(c, a, b, mr, mi, ml);
         run_op($sformatf("rnd%0d_c%0h", i, c), c, a, b, mr, (mr == 32'd0), mi, ml);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
